sme_alu_seq: RTL and testbench
==============================

// Module: sme_alu_seq
// PURPOSE
//  Sequential, parametrised masked ALU for SME. Operates on SMAX-share Boolean-masked operands.
//  Uses a runtime share count d, has valid/ready handshakes on both sides and an internal
//  2-cycle DOM AND/OR. Sits between the SME register file read stage and writeback.
// PARAMETERS
//  XLEN  32  share width in bits
//  SMAX   4  max hardware shares (>=2); RMAX = SMAX + SMAX*(SMAX-1)/2 random words
// PORTS
//  g_clk      in   1            global clock
//  g_reset    in   1            synchronous, active-high reset
//  flush      in   1            abort current op, discard result
//  smectl_d   in   4            active share count d, 2..SMAX; sampled on accept
//  rng        in   XLEN x RMAX  fresh randomness, new value every cycle
//  in_valid   in   1            request valid
//  in_ready   out  1            request accepted when in_valid && in_ready
//  op         in   4            0 XOR,1 XNOR,2 AND,3 ANDN,4 OR,5 ORN,6 SLL,7 SRL,8 ROR,9 ROL,
//                               10 MASK,11 UNMASK,12 REMASK; 13-15 illegal
//  shamt      in   5            shift/rotate amount
//  rs1,rs2    in   XLEN x SMAX  operand shares
//  out_valid  out  1            result valid; held until out_ready
//  out_ready  in   1            consumer accepts result
//  out_err    out  1            illegal op, qualified by out_valid
//  rd         out  XLEN x SMAX  result shares; shares >= d are always 0
// BEHAVIOUR
//  - Reset: state IDLE; out_valid=0, out_err=0, rd=0; in_ready=0 while g_reset=1.
//  - Accept: capture op, shamt, d, rs1, rs2. d<2 is treated as 2; d>SMAX is treated as SMAX.
//  - FSM states: IDLE, LIN, AND1, AND2, [REFR], DONE.
//    in_ready=1 only in IDLE.
//  - IDLE->LIN for linear, mask and illegal ops. IDLE->AND1 for ops 2-5.
//    LIN->DONE. AND1->AND2->DONE.
//  - DONE: out_valid=1. Go to IDLE on out_ready, which allows accept on the following cycle.
//    rd and out_err stay stable while out_ready=0.
//  - Latency from accept to out_valid: linear 2 cycles; AND/OR 3 cycles (+1 with the
//    SME_ALU_REFRESH_EN macro).
//  - flush: from any state, next state is IDLE, out_valid=0, and the captured result is dropped.
//    flush has priority over accept and over out_ready.
//  - g_reset mid-op behaves as flush and also clears rd.
//  - XOR/XNOR: rd[i]=rs1[i]^rs2[i]; XNOR inverts rs2 share 0.
//  - Shift/rotate: applied per share, no randomness. SLL/SRL fill with zeros. ROR/ROL mod XLEN.
//  - AND (DOM):
//    AND1 registers a_i&b_i and a_i&b_j ^ r_ij (i!=j, r_ij=r_ji=rng[SMAX+pair(i,j)]),
//    using rng sampled in AND1.
//    AND2 sets rd[i] = a_i&b_i ^ XOR_j(cross_ij).
//  - ANDN inverts b share 0. OR inverts a0, b0 and result share 0. ORN inverts a0 and result
//    share 0 only.
//  - MASK: rd[0]=rs1[0]^XOR(rng[1..d-1]); rd[i]=rng[i] for 1<=i<d.
//  - REMASK: d even: rd[i]=rs1[i]^rng[0] for all i<d. d odd: the same for i<d-1; rd[d-1]=rs1[d-1].
//  - UNMASK: rd[0]=XOR(rs1[0..d-1]); the other shares are 0. The XOR tree inputs are AND-gated
//    with a registered unmask-enable, so no combinational unmasking occurs for other ops.
//  - Illegal op: rd=0, out_err=1, linear latency.
//  - Share isolation: no logic combines two shares of the same operand except UNMASK and the
//    DOM compress.
// CONFIGURATION
//  SME_ALU_REFRESH_EN:
//  - Defined: an extra REFR state after AND2/LIN for ops 0-9.
//    rd[i] ^= rng[i] ^ rng[(i+1) mod d], a zero-sum ring refresh.
//    The unmasked value is unchanged and latency is +1.
//  - Undefined: no REFR state; results are output directly.
// TESTING (SMAX=4, XLEN=32)
//  1 d=3, UNMASK, rs1={12345678,FFFF0000,0000FFFF}
//    -> out_valid 2 cycles after accept, rd={EDCBA987,0,0,0}.
//  2 d=4, AND, shares XOR to F0F0F0F0 and 0FF00FF0, random rng
//    -> out_valid at +3, XOR(rd)=00F000F0.
//    The same test with OR -> XOR(rd)=FFF0FFF0.
//  3 d=2, ROL, rs1={80000001,00000003}, shamt=4 -> rd={00000018,00000030,0,0}.
//  4 d=3, REMASK, rng[0]=A5A5A5A5, rs1={1,2,3}
//    -> rd={A5A5A5A4,A5A5A5A7,00000003,0}; XOR unchanged.
//  5 AND accepted, flush asserted in AND1 -> no out_valid; in_ready=1 the next cycle.
//    A new XOR then completes normally.
//  6 XOR result with out_ready=0 for 5 cycles -> rd and out_valid stable, in_ready=0.
//    out_ready=1 -> IDLE; op=14 -> out_err=1, rd=0.

Source files
------------

// File: rtl/sme_alu_seq.sv
// Sequential masked ALU for SME: Boolean-masked operands, runtime share count,
// valid/ready on both sides, two-cycle DOM AND/OR.
// Optional feature macro: SME_ALU_REFRESH_EN (zero-sum ring refresh of results).
module sme_alu_seq #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned SMAX = 4
) (
   input  logic                                      g_clk,
   input  logic                                      g_reset,
   input  logic                                      flush,
   input  logic [3:0]                                smectl_d,
   input  logic [XLEN*(SMAX+SMAX*(SMAX-1)/2)-1:0]    rng,
   input  logic                                      in_valid,
   output logic                                      in_ready,
   input  logic [3:0]                                op,
   input  logic [4:0]                                shamt,
   input  logic [XLEN*SMAX-1:0]                      rs1,
   input  logic [XLEN*SMAX-1:0]                      rs2,
   output logic                                      out_valid,
   input  logic                                      out_ready,
   output logic                                      out_err,
   output logic [XLEN*SMAX-1:0]                      rd
);

   localparam int unsigned RMAX = SMAX + SMAX * (SMAX - 1) / 2;

   localparam logic [3:0] OP_XOR    = 4'd0;
   localparam logic [3:0] OP_XNOR   = 4'd1;
   localparam logic [3:0] OP_AND    = 4'd2;
   localparam logic [3:0] OP_ANDN   = 4'd3;
   localparam logic [3:0] OP_OR     = 4'd4;
   localparam logic [3:0] OP_ORN    = 4'd5;
   localparam logic [3:0] OP_SLL    = 4'd6;
   localparam logic [3:0] OP_SRL    = 4'd7;
   localparam logic [3:0] OP_ROR    = 4'd8;
   localparam logic [3:0] OP_ROL    = 4'd9;
   localparam logic [3:0] OP_MASK   = 4'd10;
   localparam logic [3:0] OP_UNMASK = 4'd11;
   localparam logic [3:0] OP_REMASK = 4'd12;

   typedef enum logic [2:0] {S_IDLE, S_LIN, S_AND1, S_AND2, S_REFR, S_DONE} state_t;

   state_t            state;
   logic [3:0]        op_q;
   logic [4:0]        shamt_q;
   logic [3:0]        d_q;
   logic [3:0]        d_clamp;
   logic [31:0]       d_w;
   logic              unmask_en_q;
   logic [XLEN-1:0]   a_q      [SMAX];
   logic [XLEN-1:0]   b_q      [SMAX];
   logic [XLEN-1:0]   a_eff    [SMAX];
   logic [XLEN-1:0]   b_eff    [SMAX];
   logic [XLEN-1:0]   diag_c   [SMAX];
   logic [XLEN-1:0]   diag_q   [SMAX];
   logic [XLEN-1:0]   cross_c  [SMAX][SMAX];
   logic [XLEN-1:0]   cross_q  [SMAX][SMAX];
   logic [XLEN-1:0]   and_res  [SMAX];
   logic [XLEN-1:0]   lin_res  [SMAX];
   logic [XLEN-1:0]   rd_q     [SMAX];
   logic [XLEN-1:0]   rng_a    [RMAX];
   logic [XLEN-1:0]   umx;
   logic              is_and_op;
   logic              illegal_op;

   // Random word index shared by the pair (i,j), i != j
   function automatic int unsigned pair_idx(int unsigned i, int unsigned j);
      int unsigned lo;
      int unsigned hi;
      lo = (i < j) ? i : j;
      hi = (i < j) ? j : i;
      return lo * SMAX - (lo * (lo + 1)) / 2 + (hi - lo - 1);
   endfunction

   assign in_ready   = (state == S_IDLE) && !g_reset;
   assign d_w        = 32'(d_q);
   assign is_and_op  = (op_q == OP_AND) || (op_q == OP_ANDN) || (op_q == OP_OR) || (op_q == OP_ORN);
   assign illegal_op = (op_q > OP_REMASK);

   // Clamp requested share count into 2..SMAX
   always_comb begin
      d_clamp = smectl_d;
      if (smectl_d < 4'd2)
         d_clamp = 4'd2;
      else if (smectl_d > 4'(SMAX))
         d_clamp = 4'(SMAX);
   end

   // Unpack random words and result shares
   always_comb begin
      for (int unsigned k = 0; k < RMAX; k++) rng_a[k] = rng[k*XLEN +: XLEN];
      for (int unsigned i = 0; i < SMAX; i++) rd[i*XLEN +: XLEN] = rd_q[i];
   end

   // Share-0 inversions turning DOM AND into ANDN/OR/ORN
   always_comb begin
      for (int unsigned i = 0; i < SMAX; i++) begin
         a_eff[i] = a_q[i];
         b_eff[i] = b_q[i];
      end
      case (op_q)
         OP_ANDN: b_eff[0] = ~b_q[0];
         OP_OR: begin
            a_eff[0] = ~a_q[0];
            b_eff[0] = ~b_q[0];
         end
         OP_ORN:  a_eff[0] = ~a_q[0];
         default: ;
      endcase
   end

   // DOM first stage: in-share products and refreshed cross products
   always_comb begin
      for (int unsigned i = 0; i < SMAX; i++) begin
         diag_c[i] = a_eff[i] & b_eff[i];
         for (int unsigned j = 0; j < SMAX; j++) begin
            cross_c[i][j] = '0;
            if (i != j && i < d_w && j < d_w)
               cross_c[i][j] = (a_eff[i] & b_eff[j]) ^ rng_a[SMAX + pair_idx(i, j)];
         end
      end
   end

   // DOM compress: each output share folds its own row of cross terms
   always_comb begin
      for (int unsigned i = 0; i < SMAX; i++) begin
         and_res[i] = '0;
         if (i < d_w) begin
            and_res[i] = diag_q[i];
            for (int unsigned j = 0; j < SMAX; j++) and_res[i] = and_res[i] ^ cross_q[i][j];
         end
      end
      if (op_q == OP_OR || op_q == OP_ORN) and_res[0] = ~and_res[0];
   end

   // Unmask XOR tree, gated so it only sees data during an UNMASK op
   always_comb begin
      umx = '0;
      for (int unsigned i = 0; i < SMAX; i++)
         if (i < d_w) umx = umx ^ (a_q[i] & {XLEN{unmask_en_q}});
   end

   // Linear, shift, mask and illegal-op results
   always_comb begin
      logic [2*XLEN-1:0] rot;
      logic [XLEN-1:0]   macc;
      int unsigned       sh;
      sh   = 32'(shamt_q) % XLEN;
      rot  = '0;
      macc = a_q[0];
      for (int unsigned k = 1; k < SMAX; k++)
         if (k < d_w) macc = macc ^ rng_a[k];
      for (int unsigned i = 0; i < SMAX; i++) begin
         lin_res[i] = '0;
         if (i < d_w) begin
            case (op_q)
               OP_XOR:  lin_res[i] = a_q[i] ^ b_q[i];
               OP_XNOR: lin_res[i] = a_q[i] ^ ((i == 0) ? ~b_q[i] : b_q[i]);
               OP_SLL:  lin_res[i] = a_q[i] << sh;
               OP_SRL:  lin_res[i] = a_q[i] >> sh;
               OP_ROR: begin
                  rot        = {a_q[i], a_q[i]} >> sh;
                  lin_res[i] = rot[XLEN-1:0];
               end
               OP_ROL: begin
                  rot        = {a_q[i], a_q[i]} << sh;
                  lin_res[i] = rot[2*XLEN-1:XLEN];
               end
               OP_MASK:   lin_res[i] = (i == 0) ? macc : rng_a[i];
               OP_UNMASK: lin_res[i] = (i == 0) ? umx : '0;
               OP_REMASK: lin_res[i] = (d_q[0] && i == d_w - 1) ? a_q[i] : (a_q[i] ^ rng_a[0]);
               default:   lin_res[i] = '0;
            endcase
         end
      end
   end

`ifdef SME_ALU_REFRESH_EN
   logic [XLEN-1:0] ref_res [SMAX];

   // Zero-sum ring refresh over the active shares
   always_comb begin
      for (int unsigned i = 0; i < SMAX; i++) begin
         ref_res[i] = '0;
         if (i < d_w)
            ref_res[i] = rd_q[i] ^ rng_a[i] ^ rng_a[(i + 1 == d_w) ? 0 : i + 1];
      end
   end
`endif

   // Control FSM with capture, DOM pipeline and result registers
   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         state       <= S_IDLE;
         out_valid   <= 1'b0;
         out_err     <= 1'b0;
         unmask_en_q <= 1'b0;
         for (int unsigned i = 0; i < SMAX; i++) rd_q[i] <= '0;
      end else if (flush) begin
         state       <= S_IDLE;
         out_valid   <= 1'b0;
         out_err     <= 1'b0;
         unmask_en_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  op_q        <= op;
                  shamt_q     <= shamt;
                  d_q         <= d_clamp;
                  unmask_en_q <= (op == OP_UNMASK);
                  for (int unsigned i = 0; i < SMAX; i++) begin
                     a_q[i] <= (i < 32'(d_clamp)) ? rs1[i*XLEN +: XLEN] : '0;
                     b_q[i] <= (i < 32'(d_clamp)) ? rs2[i*XLEN +: XLEN] : '0;
                  end
                  state <= (op >= OP_AND && op <= OP_ORN) ? S_AND1 : S_LIN;
               end
            end
            S_LIN: begin
               rd_q        <= lin_res;
               out_err     <= illegal_op;
               unmask_en_q <= 1'b0;
`ifdef SME_ALU_REFRESH_EN
               if (op_q <= OP_ROL) begin
                  state <= S_REFR;
               end else begin
                  state     <= S_DONE;
                  out_valid <= 1'b1;
               end
`else
               state     <= S_DONE;
               out_valid <= 1'b1;
`endif
            end
            S_AND1: begin
               diag_q  <= diag_c;
               cross_q <= cross_c;
               state   <= S_AND2;
            end
            S_AND2: begin
               rd_q    <= and_res;
               out_err <= 1'b0;
`ifdef SME_ALU_REFRESH_EN
               state   <= S_REFR;
`else
               state     <= S_DONE;
               out_valid <= 1'b1;
`endif
            end
            S_REFR: begin
`ifdef SME_ALU_REFRESH_EN
               rd_q <= ref_res;
`endif
               state     <= S_DONE;
               out_valid <= 1'b1;
            end
            S_DONE: begin
               if (out_ready) begin
                  state     <= S_IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // is_and_op documents the DOM op group; keep it observable to avoid dangling logic
   logic unused_ok;
   assign unused_ok = is_and_op;

endmodule

// File: tb/tb_sme_alu_seq.sv
// Directed self-checking bench for sme_alu_seq (XLEN=32, SMAX=4, default build).
module tb_sme_alu_seq;

   localparam int unsigned XLEN = 32;
   localparam int unsigned SMAX = 4;
   localparam int unsigned RMAX = 10;

   logic                   clk = 1'b0;
   logic                   g_reset;
   logic                   flush;
   logic [3:0]             smectl_d;
   logic [XLEN*RMAX-1:0]   rng;
   logic                   in_valid;
   logic                   in_ready;
   logic [3:0]             op;
   logic [4:0]             shamt;
   logic [XLEN*SMAX-1:0]   rs1;
   logic [XLEN*SMAX-1:0]   rs2;
   logic                   out_valid;
   logic                   out_ready;
   logic                   out_err;
   logic [XLEN*SMAX-1:0]   rd;
   logic                   rng_rand;

   int total = 0;
   int bad   = 0;

   sme_alu_seq #(.XLEN(XLEN), .SMAX(SMAX)) dut (
      .g_clk     (clk),
      .g_reset   (g_reset),
      .flush     (flush),
      .smectl_d  (smectl_d),
      .rng       (rng),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .shamt     (shamt),
      .rs1       (rs1),
      .rs2       (rs2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_err   (out_err),
      .rd        (rd)
   );

   always #5 clk = ~clk;

   // fresh randomness every cycle unless a test pins it
   always @(negedge clk) begin
      if (rng_rand)
         for (int k = 0; k < int'(RMAX); k++) rng[k*32 +: 32] = $urandom;
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] xorsh(input logic [127:0] v);
      return v[31:0] ^ v[63:32] ^ v[95:64] ^ v[127:96];
   endfunction

   function automatic logic [127:0] split(input logic [31:0] v, input int d);
      logic [127:0] r;
      logic [31:0]  acc;
      logic [31:0]  w;
      r   = '0;
      acc = v;
      for (int i = 0; i < d - 1; i++) begin
         w = $urandom;
         r[i*32 +: 32] = w;
         acc = acc ^ w;
      end
      r[(d-1)*32 +: 32] = acc;
      return r;
   endfunction

   // present one request, wait for out_valid; lat counts cycles from the accept cycle
   task automatic issue(input logic [3:0] o, input logic [3:0] d, input logic [4:0] s,
                        input logic [127:0] a, input logic [127:0] b, output int lat);
      @(negedge clk);
      op = o; smectl_d = d; shamt = s; rs1 = a; rs2 = b; in_valid = 1'b1;
      check("accept_ready", 128'(in_ready), 128'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   // hand the result to the consumer and confirm return to IDLE
   task automatic retire();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("retire_valid", 128'(out_valid), 128'(0));
      check("retire_ready", 128'(in_ready), 128'(1));
   endtask

   initial begin
      int           lat;
      logic [127:0] a;
      logic [127:0] b;
      logic [127:0] z;
      logic [127:0] hold;
      int           dl [4] = '{4, 4, 2, 3};
      logic [3:0]   ol [4] = '{4'd2, 4'd4, 4'd3, 4'd5};
      logic [31:0]  ex [4] = '{32'h00F000F0, 32'hFFF0FFF0, 32'hF000F000, 32'hF0FFF0FF};

      g_reset = 1'b1; flush = 1'b0; smectl_d = 4'd2; in_valid = 1'b0; op = '0;
      shamt = '0; rs1 = '0; rs2 = '0; out_ready = 1'b0; rng = '0; rng_rand = 1'b1;

      // reset state
      repeat (2) @(negedge clk);
      check("rst_in_ready", 128'(in_ready), 128'(0));
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_out_err", 128'(out_err), 128'(0));
      check("rst_rd", rd, 128'(0));
      g_reset = 1'b0;
      @(negedge clk);
      check("idle_in_ready", 128'(in_ready), 128'(1));

      // UNMASK d=3; share 3 holds junk that must be ignored
      issue(4'd11, 4'd3, 5'd0, {32'hDEADBEEF, 32'h0000FFFF, 32'hFFFF0000, 32'h12345678}, '0, lat);
      check("unmask_lat", 128'(lat), 128'(2));
      check("unmask_rd", rd, {96'h0, 32'hEDCBA987});
      check("unmask_err", 128'(out_err), 128'(0));
      retire();

      // DOM AND/OR family, random share splits and random rng
      for (int t = 0; t < 4; t++) begin
         a = split(32'hF0F0F0F0, dl[t]);
         b = split(32'h0FF00FF0, dl[t]);
         issue(ol[t], 4'(dl[t]), 5'd0, a, b, lat);
         check($sformatf("and_lat%0d", t), 128'(lat), 128'(3));
         check($sformatf("and_val%0d", t), 128'(xorsh(rd)), 128'(ex[t]));
         z = rd;
         for (int i = 0; i < dl[t]; i++) z[i*32 +: 32] = '0;
         check($sformatf("and_hizero%0d", t), z, 128'(0));
         retire();
      end

      // ROL d=2
      issue(4'd9, 4'd2, 5'd4, {32'h11111111, 32'h22222222, 32'h00000003, 32'h80000001}, '0, lat);
      check("rol_lat", 128'(lat), 128'(2));
      check("rol_rd", rd, {64'h0, 32'h00000030, 32'h00000018});
      retire();

      // SRL with d=0 clamped to 2
      issue(4'd7, 4'd0, 5'd8, {32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h12345678}, '0, lat);
      check("srl_rd", rd, {64'h0, 32'h00800000, 32'h00123456});
      retire();

      // XOR with d=15 clamped to 4, and XNOR d=2
      issue(4'd0, 4'd15, 5'd0, {32'h1, 32'h2, 32'h4, 32'h8}, {32'h10, 32'h20, 32'h40, 32'h80}, lat);
      check("xor_d15", rd, {32'h11, 32'h22, 32'h44, 32'h88});
      retire();
      issue(4'd1, 4'd2, 5'd0, {32'h5, 32'h6, 32'h0, 32'h0}, {32'h9, 32'h9, 32'h0, 32'h0}, lat);
      check("xnor_rd", rd, {64'h0, 32'h0, 32'hFFFFFFFF});
      retire();

      // pinned randomness for MASK / REMASK
      rng_rand = 1'b0;
      rng = '0;
      rng[31:0]  = 32'hA5A5A5A5;
      rng[63:32] = 32'h11111111;
      rng[95:64] = 32'h22222222;
      issue(4'd12, 4'd3, 5'd0, {32'h7, 32'h3, 32'h2, 32'h1}, '0, lat);
      check("remask_rd", rd, {32'h0, 32'h00000003, 32'hA5A5A5A7, 32'hA5A5A5A4});
      check("remask_xor", 128'(xorsh(rd)), 128'(32'h0));
      retire();
      issue(4'd10, 4'd3, 5'd0, {32'h0, 32'h0, 32'h0, 32'hCAFEBABE}, '0, lat);
      check("mask_rd", rd, {32'h0, 32'h22222222, 32'h11111111, 32'hF9CD898D});
      retire();
      rng_rand = 1'b1;

      // flush during AND1 drops the op
      @(negedge clk);
      op = 4'd2; smectl_d = 4'd4; rs1 = split(32'h1, 4); rs2 = split(32'h1, 4); in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      flush    = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_ready", 128'(in_ready), 128'(1));
      for (int i = 0; i < 4; i++) begin
         check("flush_novalid", 128'(out_valid), 128'(0));
         @(posedge clk); #1;
      end

      // XOR after flush, then hold with out_ready low
      issue(4'd0, 4'd2, 5'd0, {64'h0, 32'h2, 32'h1}, {64'h0, 32'h8, 32'h4}, lat);
      check("xor_lat", 128'(lat), 128'(2));
      check("xor_rd", rd, {64'h0, 32'hA, 32'h5});
      hold = {64'h0, 32'hA, 32'h5};
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("hold_rd", rd, hold);
         check("hold_valid", 128'(out_valid), 128'(1));
         check("hold_ready", 128'(in_ready), 128'(0));
      end
      retire();

      // illegal op
      issue(4'd14, 4'd2, 5'd0, {32'h1, 32'h2, 32'h3, 32'h4}, {32'h5, 32'h6, 32'h7, 32'h8}, lat);
      check("ill_lat", 128'(lat), 128'(2));
      check("ill_err", 128'(out_err), 128'(1));
      check("ill_rd", rd, 128'(0));
      retire();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
